// File: rtl/timer_counter_n.sv
// timer_counter_n
// WIDTH-bit up/down timer counter advanced by a one-cycle prescaler tick.
// Supports load, auto-reload on wrap, one-shot stop, and sticky
// overflow / underflow / compare-match flags for the register and IRQ logic.

module timer_counter_n #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] start_counter,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic             up_down,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             one_shot,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  input  logic             clr_match,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             match,
  output logic             running
);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic             tick;
  logic             at_max;
  logic             at_zero;
  logic             wrap_up;
  logic             wrap_down;
  logic [WIDTH-1:0] tick_value;

  // Qualify the tick (a load in the same cycle swallows it) and work out the value it would produce
  always_comb begin
    tick       = clk_ena & enable & (state == RUN) & ~load;
    at_max     = (count == MAX);
    at_zero    = (count == ZERO);
    wrap_up    = tick & up_down & at_max;
    wrap_down  = tick & ~up_down & at_zero;
    tick_value = count;
    if (up_down) begin
      if (at_max) begin
        tick_value = auto_reload ? start_counter : ZERO;
      end else begin
        tick_value = count + ONE;
      end
    end else begin
      if (at_zero) begin
        tick_value = auto_reload ? start_counter : MAX;
      end else begin
        tick_value = count - ONE;
      end
    end
  end

  // Counter register and RUN/DONE state: load beats tick, a one-shot wrap parks the counter in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VAL;
      state <= RUN;
    end else begin
      if (load) begin
        count <= start_counter;
      end else if (tick) begin
        count <= tick_value;
      end

      if (load) begin
        state <= RUN;
      end else if ((state == DONE) && !one_shot) begin
        state <= RUN;
      end else if ((wrap_up || wrap_down) && one_shot) begin
        state <= DONE;
      end
    end
  end

  // Sticky status flags: a set on this edge wins over a clear requested in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      match     <= 1'b0;
    end else begin
      if (wrap_up) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end

      if (wrap_down) begin
        underflow <= 1'b1;
      end else if (clr_underflow) begin
        underflow <= 1'b0;
      end

      if (tick && (tick_value == cmp_value)) begin
        match <= 1'b1;
      end else if (clr_match) begin
        match <= 1'b0;
      end
    end
  end

  assign running = enable & (state == RUN);

endmodule

// File: tb/tb_timer_counter_n.sv
// tb_timer_counter_n
// Directed scenarios plus a randomized run against an integer reference model
// of the timer counter (WIDTH=8, RST_VAL=0).

module tb_timer_counter_n;

  localparam int WIDTH = 8;
  localparam int MAXV  = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clk_ena = 1'b0;
  logic [WIDTH-1:0] start_counter = '0;
  logic [WIDTH-1:0] cmp_value = '0;
  logic             up_down = 1'b1;
  logic             load = 1'b0;
  logic             enable = 1'b1;
  logic             auto_reload = 1'b0;
  logic             one_shot = 1'b0;
  logic             clr_overflow = 1'b0;
  logic             clr_underflow = 1'b0;
  logic             clr_match = 1'b0;
  logic [WIDTH-1:0] count;
  logic             overflow;
  logic             underflow;
  logic             match;
  logic             running;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_count = 0;
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_match = 0;
  bit m_done = 0;

  timer_counter_n #(.WIDTH(WIDTH), .RST_VAL(8'd0)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_ena       (clk_ena),
    .start_counter (start_counter),
    .cmp_value     (cmp_value),
    .up_down       (up_down),
    .load          (load),
    .enable        (enable),
    .auto_reload   (auto_reload),
    .one_shot      (one_shot),
    .clr_overflow  (clr_overflow),
    .clr_underflow (clr_underflow),
    .clr_match     (clr_match),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .match         (match),
    .running       (running)
  );

  always #5 clk = ~clk;

  // Model of one clock edge using the inputs currently applied
  function automatic void model_update();
    int nxt;
    bit tk, set_o, set_u, set_m;
    if (rst) begin
      m_count = 0; m_ovf = 0; m_unf = 0; m_match = 0; m_done = 0;
      return;
    end
    tk = clk_ena && enable && !m_done;
    set_o = 0; set_u = 0; set_m = 0;
    if (load) begin
      m_count = int'(start_counter);
      m_done = 0;
    end else begin
      if (m_done && !one_shot) m_done = 0;
      if (tk) begin
        nxt = up_down ? m_count + 1 : m_count - 1;
        if (nxt > MAXV) begin
          set_o = 1;
          nxt = auto_reload ? int'(start_counter) : 0;
        end else if (nxt < 0) begin
          set_u = 1;
          nxt = auto_reload ? int'(start_counter) : MAXV;
        end
        if (nxt == int'(cmp_value)) set_m = 1;
        if ((set_o || set_u) && one_shot) m_done = 1;
        m_count = nxt;
      end
    end
    m_ovf   = set_o ? 1'b1 : (clr_overflow  ? 1'b0 : m_ovf);
    m_unf   = set_u ? 1'b1 : (clr_underflow ? 1'b0 : m_unf);
    m_match = set_m ? 1'b1 : (clr_match     ? 1'b0 : m_match);
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; clk_ena = 0; load = 0; enable = 1; auto_reload = 0; one_shot = 0;
    clr_overflow = 0; clr_underflow = 0; clr_match = 0; up_down = 1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      clk_ena = 1; step();
      clk_ena = 0; step();
    end
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    start_counter = v; load = 1; step(); load = 0;
  endtask

  task automatic clear_flags();
    clr_overflow = 1; clr_underflow = 1; clr_match = 1; step();
    clr_overflow = 0; clr_underflow = 0; clr_match = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; step(); rst = 0;
    n_checks++;
    if ({count, overflow, underflow, match, running} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL reset_state: got count=%0d ovf=%b unf=%b match=%b run=%b expected 0 0 0 0 1",
               count, overflow, underflow, match, running);
    end
    enable = 0; #1;
    n_checks++;
    if (running !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL reset_running_disabled: got %b expected 0", running);
    end
    enable = 1; #1;
  endtask

  task automatic test_overflow_wrap();
    set_idle();
    cmp_value = 8'd7;
    do_load(8'd0);
    clear_flags();
    tick_n(255);
    n_checks++;
    if ({count, overflow, underflow} !== {8'd255, 1'b0, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL ovf_before_wrap: got count=%0d ovf=%b unf=%b expected 255 0 0", count, overflow, underflow);
    end
    clk_ena = 1; step(); clk_ena = 0;
    n_checks++;
    if ({count, overflow, underflow} !== {8'd0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL ovf_at_wrap: got count=%0d ovf=%b unf=%b expected 0 1 0", count, overflow, underflow);
    end
    step();
  endtask

  task automatic test_start_no_load();
    logic [WIDTH-1:0] r;
    set_idle();
    do_load(8'd0);
    clear_flags();
    tick_n(200);
    start_counter = 8'd50;
    tick_n(55);
    n_checks++;
    if (count !== 8'd255) begin
      n_errors++;
      $display("[TB] FAIL start_change_no_load: got %0d expected 255", count);
    end
    tick_n(1);
    n_checks++;
    if ({count, overflow} !== {8'd0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL wrap_to_zero: got count=%0d ovf=%b expected 0 1", count, overflow);
    end
    r = 8'($urandom_range(1, 254));
    auto_reload = 1;
    do_load(8'd250);
    start_counter = r;
    tick_n(5);
    n_checks++;
    if (count !== 8'd255) begin
      n_errors++;
      $display("[TB] FAIL autoreload_pre: got %0d expected 255", count);
    end
    tick_n(1);
    n_checks++;
    if (count !== r) begin
      n_errors++;
      $display("[TB] FAIL autoreload_wrap: got %0d expected %0d", count, r);
    end
  endtask

  task automatic test_one_shot();
    set_idle();
    one_shot = 1; up_down = 0;
    do_load(8'd3);
    clear_flags();
    tick_n(3);
    n_checks++;
    if ({count, underflow, running} !== {8'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL oneshot_pre: got count=%0d unf=%b run=%b expected 0 0 1", count, underflow, running);
    end
    clk_ena = 1; step(); clk_ena = 0;
    n_checks++;
    if ({count, underflow, running} !== {8'd255, 1'b1, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL oneshot_wrap: got count=%0d unf=%b run=%b expected 255 1 0", count, underflow, running);
    end
    tick_n(3);
    n_checks++;
    if ({count, running} !== {8'd255, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL oneshot_hold: got count=%0d run=%b expected 255 0", count, running);
    end
    do_load(8'd10);
    n_checks++;
    if ({count, running} !== {8'd10, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL oneshot_reload: got count=%0d run=%b expected 10 1", count, running);
    end
    tick_n(1);
    n_checks++;
    if (count !== 8'd9) begin
      n_errors++;
      $display("[TB] FAIL oneshot_restart_count: got %0d expected 9", count);
    end
  endtask

  task automatic test_match();
    set_idle();
    cmp_value = 8'd20;
    do_load(8'd0);
    clear_flags();
    tick_n(19);
    n_checks++;
    if ({count, match} !== {8'd19, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL match_pre: got count=%0d match=%b expected 19 0", count, match);
    end
    clk_ena = 1; step(); clk_ena = 0;
    n_checks++;
    if ({count, match} !== {8'd20, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL match_set: got count=%0d match=%b expected 20 1", count, match);
    end
    step();
    cmp_value = 8'd21; clr_match = 1; clk_ena = 1; step(); clr_match = 0; clk_ena = 0;
    n_checks++;
    if ({count, match} !== {8'd21, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL match_set_wins: got count=%0d match=%b expected 21 1", count, match);
    end
    clr_match = 1; step(); clr_match = 0;
    n_checks++;
    if (match !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL match_clear: got %b expected 0", match);
    end
    cmp_value = 8'd40;
    do_load(8'd40);
    n_checks++;
    if ({count, match} !== {8'd40, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL match_on_load: got count=%0d match=%b expected 40 0", count, match);
    end
  endtask

  task automatic test_clear_and_load();
    logic [WIDTH-1:0] v;
    set_idle();
    do_load(8'd255);
    clear_flags();
    clk_ena = 1; step(); clk_ena = 0;
    n_checks++;
    if ({count, overflow} !== {8'd0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL clr_ovf_setup: got count=%0d ovf=%b expected 0 1", count, overflow);
    end
    clr_overflow = 1; step(); clr_overflow = 0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL clr_ovf: got %b expected 0", overflow);
    end
    do_load(8'd255);
    clr_overflow = 1; clk_ena = 1; step(); clr_overflow = 0; clk_ena = 0;
    n_checks++;
    if (overflow !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow);
    end
    v = 8'($urandom_range(1, 254));
    start_counter = v; load = 1; clk_ena = 1; step(); load = 0; clk_ena = 0;
    n_checks++;
    if (count !== v) begin
      n_errors++;
      $display("[TB] FAIL load_beats_tick: got %0d expected %0d", count, v);
    end
  endtask

  task automatic test_reset_mid();
    set_idle();
    cmp_value = 8'd50;
    do_load(8'd254);
    clear_flags();
    tick_n(2);
    tick_n(100);
    n_checks++;
    if ({count, overflow, match} !== {8'd100, 1'b1, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_setup: got count=%0d ovf=%b match=%b expected 100 1 1", count, overflow, match);
    end
    rst = 1; clk_ena = 1; step(); rst = 0; clk_ena = 0;
    n_checks++;
    if ({count, overflow, underflow, match, running} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL reset_mid: got count=%0d ovf=%b unf=%b match=%b run=%b expected 0 0 0 0 1",
               count, overflow, underflow, match, running);
    end
    one_shot = 1; up_down = 0;
    tick_n(1);
    rst = 1; step(); rst = 0;
    n_checks++;
    if ({count, underflow, running} !== {8'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("[TB] FAIL reset_in_done: got count=%0d unf=%b run=%b expected 0 0 1", count, underflow, running);
    end
  endtask

  task automatic test_random();
    logic [WIDTH+3:0] exp_v;
    set_idle();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 127) == 0);
      load          = ($urandom_range(0, 15) == 0);
      clk_ena       = $urandom_range(0, 1) != 0;
      enable        = ($urandom_range(0, 7) != 0);
      clr_overflow  = ($urandom_range(0, 7) == 0);
      clr_underflow = ($urandom_range(0, 7) == 0);
      clr_match     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) up_down = ~up_down;
      if ($urandom_range(0, 31) == 0) auto_reload = ~auto_reload;
      if ($urandom_range(0, 31) == 0) one_shot = ~one_shot;
      if ($urandom_range(0, 15) == 0) cmp_value = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 4))
        0: start_counter = 8'd0;
        1: start_counter = 8'd255;
        2: start_counter = 8'd1;
        3: start_counter = 8'd254;
        default: start_counter = 8'($urandom_range(0, 255));
      endcase
      step();
      exp_v = {8'(m_count), m_ovf, m_unf, m_match, enable & ~m_done};
      n_checks++;
      if ({count, overflow, underflow, match, running} !== exp_v) begin
        n_errors++;
        $display("[TB] FAIL random_cycle_%0d: got count=%0d ovf=%b unf=%b match=%b run=%b expected count=%0d ovf=%b unf=%b match=%b run=%b",
                 i, count, overflow, underflow, match, running,
                 exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_overflow_wrap();
    test_start_no_load();
    test_one_shot();
    test_match();
    test_clear_and_load();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
